// File: rtl/lagd_pkg.sv
// Shared definitions for the Ising core controller: register offsets,
// CTRL bit positions and the sequencer state encoding.
package lagd_pkg;

  localparam logic [7:0] ISING_CTRL_CTRL_OFFS    = 8'h00;
  localparam logic [7:0] ISING_CTRL_STATUS_OFFS  = 8'h04;
  localparam logic [7:0] ISING_CTRL_NUMITER_OFFS = 8'h08;
  localparam logic [7:0] ISING_CTRL_ITERCNT_OFFS = 8'h0C;
  localparam logic [7:0] ISING_CTRL_SETTLE_OFFS  = 8'h10;
  localparam logic [7:0] ISING_CTRL_IRQCLR_OFFS  = 8'h14;

  localparam int unsigned ISING_CTRL_START_BIT = 0;
  localparam int unsigned ISING_CTRL_ABORT_BIT = 1;
  localparam int unsigned ISING_CTRL_IRQEN_BIT = 2;

  typedef enum logic [2:0] {
    ISING_IDLE   = 3'd0,
    ISING_ISSUE  = 3'd1,
    ISING_WAIT   = 3'd2,
    ISING_SETTLE = 3'd3,
    ISING_DONE   = 3'd4
  } ising_ctrl_state_e;

  // Only address bits [4:2] select a register.
  function automatic logic [2:0] ising_reg_idx(input logic [7:0] offs);
    return offs[4:2];
  endfunction

endpackage

// File: rtl/ising_core_ctrl_regs.sv
// Register file of the Ising core controller: decode, access errors,
// job configuration storage and START/ABORT/IRQ_CLR pulse generation.
module ising_core_ctrl_regs
  import lagd_pkg::*;
#(
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned IterWidth   = 16,
  parameter int unsigned SettleWidth = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   reg_valid_i,
  input  logic                   reg_write_i,
  input  logic [AddrWidth-1:0]   reg_addr_i,
  input  logic [DataWidth-1:0]   reg_wdata_i,
  input  logic [3:0]             reg_wstrb_i,
  output logic                   reg_ready_o,
  output logic [DataWidth-1:0]   reg_rdata_o,
  output logic                   reg_error_o,
  input  logic                   busy_i,
  input  logic                   done_i,
  input  logic                   aborted_i,
  input  logic [IterWidth-1:0]   iter_cnt_i,
  output logic                   start_o,
  output logic                   abort_o,
  output logic                   irq_clr_o,
  output logic                   irq_en_o,
  output logic [IterWidth-1:0]   num_iter_o,
  output logic [SettleWidth-1:0] settle_o
);

  localparam logic [2:0] IdxCtrl    = ising_reg_idx(ISING_CTRL_CTRL_OFFS);
  localparam logic [2:0] IdxStatus  = ising_reg_idx(ISING_CTRL_STATUS_OFFS);
  localparam logic [2:0] IdxNumIter = ising_reg_idx(ISING_CTRL_NUMITER_OFFS);
  localparam logic [2:0] IdxIterCnt = ising_reg_idx(ISING_CTRL_ITERCNT_OFFS);
  localparam logic [2:0] IdxSettle  = ising_reg_idx(ISING_CTRL_SETTLE_OFFS);
  localparam logic [2:0] IdxIrqClr  = ising_reg_idx(ISING_CTRL_IRQCLR_OFFS);

  logic [IterWidth-1:0]   num_iter_d, num_iter_q;
  logic [SettleWidth-1:0] settle_d, settle_q;
  logic                   irq_en_d, irq_en_q;
  logic [2:0]             addr_idx_s;
  logic                   strb_ok_s;
  logic                   err_s, start_s, abort_s, irq_clr_s;
  logic [DataWidth-1:0]   rdata_s;
  logic                   unused_s;

  assign addr_idx_s = reg_addr_i[4:2];
  assign strb_ok_s  = (reg_wstrb_i == 4'hF);
  assign unused_s   = ^{reg_addr_i[AddrWidth-1:5], reg_addr_i[1:0], reg_wdata_i};

  // Decode one access; any error drops the whole write and reads back zero.
  always_comb begin
    num_iter_d = num_iter_q;
    settle_d   = settle_q;
    irq_en_d   = irq_en_q;
    err_s      = 1'b0;
    rdata_s    = '0;
    start_s    = 1'b0;
    abort_s    = 1'b0;
    irq_clr_s  = 1'b0;
    if (reg_valid_i) begin
      case (addr_idx_s)
        IdxCtrl: begin
          if (!reg_write_i) begin
            rdata_s = DataWidth'({irq_en_q, 2'b00});
          end else if (!strb_ok_s) begin
            err_s = 1'b1;
          end else if (reg_wdata_i[ISING_CTRL_ABORT_BIT]) begin
            // ABORT overrides a START in the same write
            abort_s  = 1'b1;
            irq_en_d = reg_wdata_i[ISING_CTRL_IRQEN_BIT];
          end else if (reg_wdata_i[ISING_CTRL_START_BIT] && busy_i) begin
            err_s = 1'b1;
          end else begin
            start_s  = reg_wdata_i[ISING_CTRL_START_BIT];
            irq_en_d = reg_wdata_i[ISING_CTRL_IRQEN_BIT];
          end
        end
        IdxStatus: begin
          if (!reg_write_i) begin
            rdata_s = DataWidth'({aborted_i, done_i, busy_i});
          end else begin
            err_s = 1'b1;
          end
        end
        IdxNumIter: begin
          if (!reg_write_i) begin
            rdata_s = DataWidth'(num_iter_q);
          end else if (!strb_ok_s || busy_i) begin
            err_s = 1'b1;
          end else begin
            num_iter_d = reg_wdata_i[IterWidth-1:0];
          end
        end
        IdxIterCnt: begin
          if (!reg_write_i) begin
            rdata_s = DataWidth'(iter_cnt_i);
          end else begin
            err_s = 1'b1;
          end
        end
        IdxSettle: begin
          if (!reg_write_i) begin
            rdata_s = DataWidth'(settle_q);
          end else if (!strb_ok_s || busy_i) begin
            err_s = 1'b1;
          end else begin
            settle_d = reg_wdata_i[SettleWidth-1:0];
          end
        end
        IdxIrqClr: begin
          if (!reg_write_i) begin
            rdata_s = '0;
          end else if (!strb_ok_s) begin
            err_s = 1'b1;
          end else begin
            irq_clr_s = reg_wdata_i[0];
          end
        end
        default: begin
          err_s = 1'b1;
        end
      endcase
    end else begin
      err_s = 1'b0;
    end
  end

  // Configuration storage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      num_iter_q <= '0;
      settle_q   <= '0;
      irq_en_q   <= 1'b0;
    end else begin
      num_iter_q <= num_iter_d;
      settle_q   <= settle_d;
      irq_en_q   <= irq_en_d;
    end
  end

  assign reg_ready_o = reg_valid_i;
  assign reg_rdata_o = rdata_s;
  assign reg_error_o = err_s;
  assign start_o     = start_s;
  assign abort_o     = abort_s;
  assign irq_clr_o   = irq_clr_s;
  assign irq_en_o    = irq_en_q;
  assign num_iter_o  = num_iter_q;
  assign settle_o    = settle_q;

endmodule

// File: rtl/ising_core_ctrl.sv
// Ising core controller: sequences NUM_ITER issue/wait/settle rounds on the
// core datapath and raises a maskable done interrupt.
module ising_core_ctrl
  import lagd_pkg::*;
#(
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned IterWidth   = 16,
  parameter int unsigned SettleWidth = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 reg_valid_i,
  input  logic                 reg_write_i,
  input  logic [AddrWidth-1:0] reg_addr_i,
  input  logic [DataWidth-1:0] reg_wdata_i,
  input  logic [3:0]           reg_wstrb_i,
  output logic                 reg_ready_o,
  output logic [DataWidth-1:0] reg_rdata_o,
  output logic                 reg_error_o,
  output logic                 iter_valid_o,
  input  logic                 iter_ready_i,
  output logic [IterWidth-1:0] iter_idx_o,
  input  logic                 iter_done_i,
  output logic                 abort_o,
  output logic                 irq_o
);

  ising_ctrl_state_e      state_d, state_q;
  logic [IterWidth-1:0]   iter_cnt_d, iter_cnt_q;
  logic [SettleWidth-1:0] settle_cnt_d, settle_cnt_q;
  logic                   done_d, done_q;
  logic                   aborted_d, aborted_q;
  logic                   iter_valid_d, iter_valid_q;
  logic [IterWidth-1:0]   iter_idx_d, iter_idx_q;
  logic                   abort_d, abort_q;
  logic                   irq_d, irq_q;

  logic                   busy_s, start_s, abort_req_s, irq_clr_s, irq_en_s;
  logic [IterWidth-1:0]   num_iter_s;
  logic [SettleWidth-1:0] settle_s;

  assign busy_s = (state_q == ISING_ISSUE) || (state_q == ISING_WAIT) ||
                  (state_q == ISING_SETTLE);

  ising_core_ctrl_regs #(
    .AddrWidth   (AddrWidth),
    .DataWidth   (DataWidth),
    .IterWidth   (IterWidth),
    .SettleWidth (SettleWidth)
  ) u_regs (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .reg_valid_i (reg_valid_i),
    .reg_write_i (reg_write_i),
    .reg_addr_i  (reg_addr_i),
    .reg_wdata_i (reg_wdata_i),
    .reg_wstrb_i (reg_wstrb_i),
    .reg_ready_o (reg_ready_o),
    .reg_rdata_o (reg_rdata_o),
    .reg_error_o (reg_error_o),
    .busy_i      (busy_s),
    .done_i      (done_q),
    .aborted_i   (aborted_q),
    .iter_cnt_i  (iter_cnt_q),
    .start_o     (start_s),
    .abort_o     (abort_req_s),
    .irq_clr_o   (irq_clr_s),
    .irq_en_o    (irq_en_s),
    .num_iter_o  (num_iter_s),
    .settle_o    (settle_s)
  );

  // Sequencer next-state, counters, flags and registered output values.
  always_comb begin
    state_d      = state_q;
    iter_cnt_d   = iter_cnt_q;
    settle_cnt_d = settle_cnt_q;
    aborted_d    = aborted_q;
    abort_d      = 1'b0;
    done_d       = irq_clr_s ? 1'b0 : done_q;
    if (abort_req_s && (state_q != ISING_IDLE)) begin
      state_d   = ISING_IDLE;
      aborted_d = 1'b1;
      abort_d   = 1'b1;
    end else begin
      case (state_q)
        ISING_IDLE, ISING_DONE: begin
          if (start_s) begin
            done_d     = 1'b0;
            aborted_d  = 1'b0;
            iter_cnt_d = '0;
            state_d    = (num_iter_s == '0) ? ISING_DONE : ISING_ISSUE;
          end else if (state_q == ISING_DONE) begin
            // setting done takes priority over a concurrent IRQ_CLR
            done_d  = 1'b1;
            state_d = ISING_IDLE;
          end else begin
            state_d = ISING_IDLE;
          end
        end
        ISING_ISSUE: begin
          if (iter_ready_i) begin
            state_d = ISING_WAIT;
          end else begin
            state_d = ISING_ISSUE;
          end
        end
        ISING_WAIT: begin
          if (iter_done_i) begin
            state_d      = ISING_SETTLE;
            settle_cnt_d = settle_s;
          end else begin
            state_d = ISING_WAIT;
          end
        end
        ISING_SETTLE: begin
          if (settle_cnt_q == '0) begin
            iter_cnt_d = iter_cnt_q + IterWidth'(1'b1);
            state_d    = (iter_cnt_d == num_iter_s) ? ISING_DONE : ISING_ISSUE;
          end else begin
            settle_cnt_d = settle_cnt_q - SettleWidth'(1'b1);
          end
        end
        default: begin
          state_d = ISING_IDLE;
        end
      endcase
    end
    iter_valid_d = (state_d == ISING_ISSUE);
    iter_idx_d   = iter_valid_d ? iter_cnt_d : '0;
    irq_d        = done_d & irq_en_s;
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ISING_IDLE;
      iter_cnt_q   <= '0;
      settle_cnt_q <= '0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      iter_valid_q <= 1'b0;
      iter_idx_q   <= '0;
      abort_q      <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      iter_cnt_q   <= iter_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      iter_valid_q <= iter_valid_d;
      iter_idx_q   <= iter_idx_d;
      abort_q      <= abort_d;
      irq_q        <= irq_d;
    end
  end

  assign iter_valid_o = iter_valid_q;
  assign iter_idx_o   = iter_idx_q;
  assign abort_o      = abort_q;
  assign irq_o        = irq_q;

endmodule

// File: tb/tb_ising_core_ctrl.sv
// Self-checking bench for ising_core_ctrl: directed scenarios plus random
// jobs checked against a timing model derived from the sequencing rules.
module tb_ising_core_ctrl;

  localparam logic [31:0] A_CTRL   = 32'h00;
  localparam logic [31:0] A_STATUS = 32'h04;
  localparam logic [31:0] A_NUM    = 32'h08;
  localparam logic [31:0] A_ITER   = 32'h0C;
  localparam logic [31:0] A_SETTLE = 32'h10;
  localparam logic [31:0] A_IRQCLR = 32'h14;

  logic        clk_i;
  logic        rst_i;
  logic        reg_valid_i;
  logic        reg_write_i;
  logic [31:0] reg_addr_i;
  logic [31:0] reg_wdata_i;
  logic [3:0]  reg_wstrb_i;
  logic        reg_ready_o;
  logic [31:0] reg_rdata_o;
  logic        reg_error_o;
  logic        iter_valid_o;
  logic        iter_ready_i;
  logic [15:0] iter_idx_o;
  logic        iter_done_i;
  logic        abort_o;
  logic        irq_o;

  int n_assert = 0;
  int n_fail   = 0;

  ising_core_ctrl dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .reg_valid_i  (reg_valid_i),
    .reg_write_i  (reg_write_i),
    .reg_addr_i   (reg_addr_i),
    .reg_wdata_i  (reg_wdata_i),
    .reg_wstrb_i  (reg_wstrb_i),
    .reg_ready_o  (reg_ready_o),
    .reg_rdata_o  (reg_rdata_o),
    .reg_error_o  (reg_error_o),
    .iter_valid_o (iter_valid_o),
    .iter_ready_i (iter_ready_i),
    .iter_idx_o   (iter_idx_o),
    .iter_done_i  (iter_done_i),
    .abort_o      (abort_o),
    .irq_o        (irq_o)
  );

  initial clk_i = 1'b0;
  always #10 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk_i);
    #2;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data,
                    input logic [3:0] strb, input logic exp_err);
    reg_valid_i = 1'b1;
    reg_write_i = 1'b1;
    reg_addr_i  = addr;
    reg_wdata_i = data;
    reg_wstrb_i = strb;
    #1;
    chk("wr_ready", {31'd0, reg_ready_o}, 32'd1);
    chk($sformatf("wr_err@%0h", addr), {31'd0, reg_error_o}, {31'd0, exp_err});
    cycle();
    reg_valid_i = 1'b0;
    reg_write_i = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input logic exp_err);
    reg_valid_i = 1'b1;
    reg_write_i = 1'b0;
    reg_addr_i  = addr;
    reg_wstrb_i = 4'h0;
    #1;
    chk($sformatf("rd_err@%0h", addr), {31'd0, reg_error_o}, {31'd0, exp_err});
    chk($sformatf("rd_data@%0h", addr), reg_rdata_o, exp);
    reg_valid_i = 1'b0;
  endtask

  // One iteration k: ready after rl cycles, done dl cycles after handshake,
  // then expect exactly S+1 idle cycles before the sequencer moves on.
  task automatic do_iter(input int k, input int s, input int rl, input int dl);
    chk($sformatf("valid_k%0d", k), {31'd0, iter_valid_o}, 32'd1);
    chk($sformatf("idx_k%0d", k), {16'd0, iter_idx_o}, k);
    for (int i = 0; i < rl; i++) begin
      cycle();
      chk("valid_hold", {31'd0, iter_valid_o}, 32'd1);
      chk("idx_hold", {16'd0, iter_idx_o}, k);
    end
    iter_ready_i = 1'b1;
    cycle();
    iter_ready_i = 1'b0;
    chk("valid_after_hs", {31'd0, iter_valid_o}, 32'd0);
    for (int i = 1; i < dl; i++) cycle();
    iter_done_i = 1'b1;
    cycle();
    iter_done_i = 1'b0;
    for (int i = 0; i <= s; i++) begin
      chk("settle_gap", {31'd0, iter_valid_o}, 32'd0);
      cycle();
    end
  endtask

  task automatic run_job(input int num, input int s, input logic en, input int rl, input int dl);
    wr(A_NUM, num, 4'hF, 1'b0);
    wr(A_SETTLE, s, 4'hF, 1'b0);
    wr(A_CTRL, {29'd0, en, 2'b01}, 4'hF, 1'b0);
    for (int k = 0; k < num; k++) do_iter(k, s, rl, dl);
    chk("job_valid_end", {31'd0, iter_valid_o}, 32'd0);
    rd(A_STATUS, 32'd0, 1'b0);
    cycle();
    rd(A_STATUS, 32'd2, 1'b0);
    rd(A_ITER, num, 1'b0);
    chk("irq_done", {31'd0, irq_o}, {31'd0, en});
    wr(A_IRQCLR, 32'd1, 4'hF, 1'b0);
    chk("irq_clr", {31'd0, irq_o}, 32'd0);
    rd(A_STATUS, 32'd0, 1'b0);
  endtask

  initial begin
    rst_i        = 1'b1;
    reg_valid_i  = 1'b0;
    reg_write_i  = 1'b0;
    reg_addr_i   = 32'd0;
    reg_wdata_i  = 32'd0;
    reg_wstrb_i  = 4'h0;
    iter_ready_i = 1'b0;
    iter_done_i  = 1'b0;
    cycle();
    cycle();
    rst_i = 1'b0;
    chk("rst_valid", {31'd0, iter_valid_o}, 32'd0);
    chk("rst_idx", {16'd0, iter_idx_o}, 32'd0);
    chk("rst_abort", {31'd0, abort_o}, 32'd0);
    chk("rst_irq", {31'd0, irq_o}, 32'd0);
    rd(A_STATUS, 32'd0, 1'b0);
    rd(A_NUM, 32'd0, 1'b0);
    rd(A_CTRL, 32'd0, 1'b0);
    cycle();

    // Plan 1: three iterations, immediate ready, done 4 cycles later.
    run_job(3, 2, 1'b1, 0, 4);

    // Plan 2: zero iterations goes straight to done.
    wr(A_NUM, 32'd0, 4'hF, 1'b0);
    wr(A_CTRL, 32'h1, 4'hF, 1'b0);
    chk("z_valid", {31'd0, iter_valid_o}, 32'd0);
    rd(A_STATUS, 32'd0, 1'b0);
    cycle();
    rd(A_STATUS, 32'd2, 1'b0);
    rd(A_ITER, 32'd0, 1'b0);
    chk("z_irq_masked", {31'd0, irq_o}, 32'd0);
    wr(A_IRQCLR, 32'd1, 4'hF, 1'b0);

    // Plan 3: ready held low for 10 cycles.
    run_job(1, 0, 1'b0, 10, 1);

    // Plan 4: abort in WAIT at ITER_CNT=2.
    wr(A_NUM, 32'd5, 4'hF, 1'b0);
    wr(A_SETTLE, 32'd1, 4'hF, 1'b0);
    wr(A_CTRL, 32'h5, 4'hF, 1'b0);
    do_iter(0, 1, 0, 2);
    do_iter(1, 1, 1, 1);
    chk("ab_idx", {16'd0, iter_idx_o}, 32'd2);
    iter_ready_i = 1'b1;
    cycle();
    iter_ready_i = 1'b0;
    wr(A_CTRL, 32'h6, 4'hF, 1'b0);
    chk("ab_pulse", {31'd0, abort_o}, 32'd1);
    chk("ab_valid", {31'd0, iter_valid_o}, 32'd0);
    cycle();
    chk("ab_pulse_end", {31'd0, abort_o}, 32'd0);
    rd(A_STATUS, 32'd4, 1'b0);
    rd(A_ITER, 32'd2, 1'b0);
    chk("ab_irq", {31'd0, irq_o}, 32'd0);
    iter_done_i = 1'b1;
    cycle();
    iter_done_i = 1'b0;
    cycle();
    chk("stray_done_valid", {31'd0, iter_valid_o}, 32'd0);
    rd(A_STATUS, 32'd4, 1'b0);
    wr(A_CTRL, 32'h2, 4'hF, 1'b0);
    chk("idle_abort", {31'd0, abort_o}, 32'd0);
    rd(A_STATUS, 32'd4, 1'b0);
    wr(A_CTRL, 32'h3, 4'hF, 1'b0);
    chk("idle_start_abort", {31'd0, iter_valid_o}, 32'd0);
    rd(A_STATUS, 32'd4, 1'b0);

    // Plan 5: access errors while busy and in general.
    wr(A_NUM, 32'd2, 4'hF, 1'b0);
    wr(A_SETTLE, 32'd0, 4'hF, 1'b0);
    wr(A_CTRL, 32'h1, 4'hF, 1'b0);
    wr(A_NUM, 32'd7, 4'hF, 1'b1);
    wr(A_CTRL, 32'h1, 4'hF, 1'b1);
    rd(A_NUM, 32'd2, 1'b0);
    rd(32'h18, 32'd0, 1'b1);
    wr(A_STATUS, 32'd1, 4'hF, 1'b1);
    wr(A_SETTLE, 32'd5, 4'h3, 1'b1);
    rd(A_SETTLE, 32'd0, 1'b0);
    rd(A_STATUS, 32'd1, 1'b0);
    chk("busy_valid", {31'd0, iter_valid_o}, 32'd1);
    chk("busy_idx", {16'd0, iter_idx_o}, 32'd0);
    wr(A_CTRL, 32'h3, 4'hF, 1'b0);
    chk("sa_abort", {31'd0, abort_o}, 32'd1);
    cycle();
    rd(A_STATUS, 32'd4, 1'b0);
    wr(A_NUM, 32'd9, 4'h3, 1'b1);
    rd(A_NUM, 32'd2, 1'b0);

    // Plan 6: reset during SETTLE.
    wr(A_NUM, 32'd2, 4'hF, 1'b0);
    wr(A_SETTLE, 32'd3, 4'hF, 1'b0);
    wr(A_CTRL, 32'h5, 4'hF, 1'b0);
    iter_ready_i = 1'b1;
    cycle();
    iter_ready_i = 1'b0;
    iter_done_i = 1'b1;
    cycle();
    iter_done_i = 1'b0;
    cycle();
    rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
    chk("mr_valid", {31'd0, iter_valid_o}, 32'd0);
    chk("mr_idx", {16'd0, iter_idx_o}, 32'd0);
    chk("mr_abort", {31'd0, abort_o}, 32'd0);
    chk("mr_irq", {31'd0, irq_o}, 32'd0);
    rd(A_STATUS, 32'd0, 1'b0);
    rd(A_NUM, 32'd0, 1'b0);
    rd(A_SETTLE, 32'd0, 1'b0);
    rd(A_ITER, 32'd0, 1'b0);
    rd(A_CTRL, 32'd0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("mr_quiet", {30'd0, abort_o, iter_valid_o}, 32'd0);
    end

    // Random jobs against the timing model.
    for (int j = 0; j < 8; j++) begin
      run_job($urandom_range(4, 1), $urandom_range(5, 0), 1'($urandom_range(1, 0)),
              $urandom_range(4, 0), $urandom_range(5, 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
